// File: rtl/seq_detect_param_pkg.sv
// Shared types for the programmable serial pattern detector.
package seq_detect_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_e;

endpackage

// File: rtl/seq_detect_param_if.sv
// Configuration, serial stream and status bundle for seq_detect_param.
interface seq_detect_param_if
    import seq_detect_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic               cfg_overlap;
    logic               in_valid;
    logic               inp;
    logic               outp;
    logic [CNT_W-1:0]   match_count;
    logic [STATE_W-1:0] state;

    modport master (
        output cfg_load, cfg_pattern, cfg_overlap, in_valid, inp,
        input  outp, match_count, state
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_overlap, in_valid, inp,
        output outp, match_count, state
    );

endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Up-counter that holds at all-ones; clr wins over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime pattern, overlap mode and saturating match count.
//   state | meaning
//   IDLE  | unconfigured, stream ignored until cfg_load
//   FILL  | collecting fresh bits, fewer than PAT_LEN-1 held
//   HUNT  | window primed, every accepted bit is compared
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_param_if.slave  bus
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);

    state_e             state_q, state_d;
    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic               overlap_q, overlap_d;
    logic [PAT_LEN-1:0] window_q, window_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               outp_q, outp_d;

    logic               accept;
    logic               hit;
    logic [PAT_LEN-1:0] shifted;
    logic [FILL_W-1:0]  fill_inc;
    logic               cnt_clr;
    logic               cnt_inc;
    logic [CNT_W-1:0]   cnt_q;

    // A load cycle swallows any bit presented alongside it.
    assign accept   = bus.in_valid && !bus.cfg_load && ((state_q == FILL) || (state_q == HUNT));
    assign shifted  = {window_q[PAT_LEN-2:0], bus.inp};
    assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
    assign hit      = accept && (fill_q >= FILL_LAST) && (shifted == pattern_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.cfg_load) begin
            state_d = FILL;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                FILL: if (accept && (fill_inc == FILL_LAST)) state_d = HUNT;
                HUNT: if (hit && !overlap_q) state_d = FILL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        window_d  = window_q;
        fill_d    = fill_q;
        outp_d    = hit;
        cnt_clr   = bus.cfg_load;
        cnt_inc   = hit;
        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            overlap_d = bus.cfg_overlap;
            window_d  = '0;
            fill_d    = '0;
            outp_d    = 1'b0;
        end else if (accept) begin
            window_d = shifted;
            fill_d   = (hit && !overlap_q) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= '0;
            overlap_q <= 1'b0;
            window_q  <= '0;
            fill_q    <= '0;
            outp_q    <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            window_q  <= window_d;
            fill_q    <= fill_d;
            outp_q    <= outp_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .q   (cnt_q)
    );

    assign bus.outp        = outp_q;
    assign bus.match_count = cnt_q;
    assign bus.state       = state_q;

endmodule
